// File: rtl/amba3_apb_arbiter.sv
// rtl/amba3_apb_arbiter.sv - round-robin arbiter sharing one AMBA 3 APB master port
// Each requester posts one transfer on valid/done; a pready watchdog aborts hung slaves.
module amba3_apb_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [DATA_SIZE-1:0]           rsp_rdata,
  output logic                           rsp_slverr,
  output logic                           rsp_timeout,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_SIZE-1:0]           paddr,
  output logic [DATA_SIZE-1:0]           pwdata,
  input  logic [DATA_SIZE-1:0]           prdata,
  input  logic                           pready,
  input  logic                           pslverr
);

  localparam int IDW = $clog2(NUM_REQ);
  // Keep the wait counter at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic [WCW-1:0]         wcnt_q, wcnt_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_SIZE-1:0]   paddr_q, paddr_d;
  logic [DATA_SIZE-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]     req_done_q, req_done_d;
  logic [DATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_slverr_q, rsp_slverr_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic                   busy_q, busy_d;

  logic                   pick_found;
  logic [IDW-1:0]         pick_idx;
  logic                   sel_write;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [DATA_SIZE-1:0]   sel_wdata;
  logic                   timeout_hit;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req_valid[IDW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
        sel_wdata = req_wdata[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign timeout_hit = TO_EN && !pready && (wcnt_q == WC_LAST);

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      wcnt_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      req_done_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      wcnt_q        <= wcnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      req_done_q    <= req_done_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pick_found) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || timeout_hit) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; completion is flagged on entry to DONE.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    wcnt_d        = wcnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    req_done_d    = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          paddr_d    = sel_addr;
          pwrite_d   = sel_write;
          pwdata_d   = sel_write ? sel_wdata : '0;
          psel_d     = 1'b1;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        wcnt_d    = '0;
      end
      S_ACCESS: begin
        if (pready) begin
          rsp_rdata_d             = pwrite_q ? '0 : prdata;
          rsp_slverr_d            = pslverr;
          rsp_timeout_d           = 1'b0;
          psel_d                  = 1'b0;
          penable_d               = 1'b0;
          req_done_d[grant_id_q]  = 1'b1;
        end else if (timeout_hit) begin
          rsp_rdata_d             = '0;
          rsp_slverr_d            = 1'b1;
          rsp_timeout_d           = 1'b1;
          psel_d                  = 1'b0;
          penable_d               = 1'b0;
          req_done_d[grant_id_q]  = 1'b1;
        end else if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      S_DONE: begin
        rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign req_done    = req_done_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;

endmodule

// File: doc/amba3_apb_arbiter.md
# amba3_apb_arbiter

Shares one AMBA 3 APB master port among NUM_REQ local requesters. Each requester posts a single read or write on a valid/done handshake; the block grants requesters round-robin and sequences the APB SETUP/ACCESS phases. It completes or aborts each transfer, with a pready watchdog, and returns read data and error status. It sits between on-chip control agents and the `amba3_apb_if` bus driven to APB slaves.

## Interface
- ADDR_SIZE, 32, address width
- DATA_SIZE, 32, data width
- NUM_REQ, 4, number of requesters (2..16)
- TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables
- pclk  in  1  clock, all logic on rising edge
- preset_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request pending
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
- req_wdata  in  NUM_REQ*DATA_SIZE  packed write data
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- rsp_rdata  out  DATA_SIZE  read data, valid while req_done != 0
- rsp_slverr  out  1  pslverr sampled at completion, or forced 1 on timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- busy  out  1  state != IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- psel, penable, pwrite  out  1  APB controls
- paddr  out  ADDR_SIZE  APB address
- pwdata  out  DATA_SIZE  APB write data
- prdata  in  DATA_SIZE  APB read data
- pready, pslverr  in  1  APB response

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. Every output is registered.
- IDLE
  - If any req_valid is high: pick the first set bit, searching upward from rr_ptr with wrap.
  - Latch grant_id, paddr, pwrite, and pwdata (pwdata = 0 for reads).
  - Set psel = 1 and go to SETUP. Otherwise stay in IDLE.
- SETUP
  - psel = 1, penable = 0.
  - Go to ACCESS with penable = 1.
  - Clear the wait counter wcnt to 0.
- ACCESS, pready = 1
  - Capture prdata (0 for writes) into rsp_rdata and pslverr into rsp_slverr.
  - rsp_timeout = 0.
  - Drop psel and penable.
  - Go to DONE.
- ACCESS, pready = 0
  - If TIMEOUT != 0 and wcnt == TIMEOUT-1: abort. Set rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0, drop psel and penable, go to DONE.
  - Otherwise wcnt++ and stay in ACCESS.
- DONE
  - req_done[grant_id] = 1 for exactly this cycle.
  - Set rr_ptr = (grant_id+1) mod NUM_REQ.
  - Go to IDLE.
- Requester rules
  - Hold req_valid, write, addr, and wdata stable from assertion until the cycle after its req_done pulse.
  - In that cycle it may deassert valid or present the next request.
- Arbiter rules
  - Requests are never dropped.
  - A requester whose valid falls while pending and ungranted is simply skipped.
  - paddr, pwrite, and pwdata stay stable from SETUP through the end of ACCESS.
  - rsp_* hold their values until the next completion.
- Width rules
  - wcnt is $clog2(TIMEOUT+1) bits and does not wrap.
  - rr_ptr and grant_id are $clog2(NUM_REQ) bits.

## Timing
- Reset values:
  - All APB outputs (psel, penable, paddr, pwrite, pwdata) = 0.
  - req_done, rsp_rdata, rsp_slverr, rsp_timeout, busy, grant_id = 0.
  - rr_ptr = 0; state = IDLE.
- Reset mid-transfer: on the first edge with preset_n low, every output returns to its reset value. psel and penable drop immediately, no req_done is issued, and the transfer is lost.
- Latency with zero wait states: req_valid sampled in IDLE at edge 0.
  - Edge 1: SETUP.
  - Edge 2: ACCESS.
  - Edge 3: DONE, with req_done high.
  - Edge 4: IDLE.
  - Back-to-back throughput is one transfer per 4 cycles.
- Each pready-low cycle in ACCESS adds one cycle.
- Timeout abort happens on the TIMEOUT-th consecutive pready-low ACCESS cycle; DONE follows on the next edge.
- pslverr and prdata are sampled only in ACCESS cycles where pready = 1 (or on the abort cycle).
- Simultaneous valids: exactly one is granted per IDLE cycle; losers wait. There is no starvation: any held request is served within NUM_REQ transfers.
- A request rising during SETUP, ACCESS or DONE is considered only at the next IDLE.

## Test plan
- Single write: requester 2 writes addr 0x00000040, data 0x12345678, pready = 1.
  - APB sees psel for 2 cycles, penable in the 2nd, pwrite = 1.
  - req_done = 4'b0100 on the 3rd cycle after the request; rsp_slverr = 0.
- Single read with 3 wait states: requester 0 reads 0x00000018; slave returns 0x22446688 after 3 pready-low cycles.
  - rsp_rdata = 0x22446688 when req_done[0] pulses, 6 cycles after the request.
- Contention: all 4 valids raised together and held (each re-requests after its done).
  - Grant order is 0,1,2,3,0,1.
  - Each requester sees exactly one req_done per 4 transfers.
- Error: slave returns pslverr = 1 with pready = 1 on a write from requester 3 → rsp_slverr = 1, rsp_timeout = 0.
- Timeout: TIMEOUT = 16, slave holds pready = 0.
  - psel and penable drop after 16 ACCESS cycles.
  - req_done pulses with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
- Reset mid-ACCESS: preset_n driven low for 1 cycle during a wait state.
  - Next edge: psel = penable = 0, no req_done, and rr_ptr = 0, so requester 0 wins the next contention.
